// File: rtl/mppt_seq_pkg.sv
// Shared constants for the MPPT measurement sequencer: state encoding,
// timer flag codes, enable patterns and default timing values.
package mppt_seq_pkg;

  // All eight codes are named so the decoder can treat 6 and 7 explicitly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMP_V = 3'd2,
    ST_SAMP_I = 3'd3,
    ST_CALC   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_BAD6   = 3'd6,
    ST_BAD7   = 3'd7
  } state_t;

  // Timer flag codes produced from the iteration counter.
  localparam logic [1:0] FLAG_NONE   = 2'b00;
  localparam logic [1:0] FLAG_SAMPLE = 2'b01;
  localparam logic [1:0] FLAG_SETTLE = 2'b10;
  localparam logic [1:0] FLAG_WDOG   = 2'b11;

  // One-hot enable patterns: [0] sample V, [1] sample I, [2] power, [3] duty.
  localparam logic [3:0] EN_NONE   = 4'b0000;
  localparam logic [3:0] EN_SAMP_V = 4'b0001;
  localparam logic [3:0] EN_SAMP_I = 4'b0010;
  localparam logic [3:0] EN_CALC   = 4'b0100;
  localparam logic [3:0] EN_UPDATE = 4'b1000;

  // 200 us settle and 1 us sample windows at a 50 MHz clock.
  localparam int SETTLE_CNT_DEF = 9999;
  localparam int SAMPLE_CNT_DEF = 49;

endpackage

// File: rtl/mppt_sequencer_cnt_iter.sv
// Iteration counter: clears on request, otherwise counts up and sticks at
// all-ones so an overrun is visible to the watchdog flag.
module cnt_iter #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_ci,
  output logic [CNT_W-1:0] c_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  // Count register: reset/clear to zero, saturating increment otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (rst_ci) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

  assign c_i = count;

endmodule

// File: rtl/mppt_sequencer.sv
// MPPT measurement sequencer: settle, sample V, sample I, compute power,
// update duty, repeat. Timing comes from one shared iteration counter whose
// terminal values are decoded into a flag and registered before the FSM
// decoder sees them, which adds one cycle to every timed state.
module mppt_sequencer
  import mppt_seq_pkg::*;
#(
  parameter int CNT_W      = 14,
  parameter int SETTLE_CNT = SETTLE_CNT_DEF,
  parameter int SAMPLE_CNT = SAMPLE_CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] c_i,
  output logic [1:0]       flag_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CNT);
  localparam logic [CNT_W-1:0] SAMPLE_VAL = CNT_W'(SAMPLE_CNT);

  state_t     state_q;
  state_t     nstate;
  logic [1:0] flag_i;
  logic       rst_ci;

  cnt_iter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .rst_ci (rst_ci),
    .c_i    (c_i)
  );

  // Flag decode: mark the counter values that end a window or signal overrun.
  always_comb begin
    flag_i = FLAG_NONE;
    if (c_i == CNT_MAX) begin
      flag_i = FLAG_WDOG;
    end else if (c_i == SETTLE_VAL) begin
      flag_i = FLAG_SETTLE;
    end else if (c_i == SAMPLE_VAL) begin
      flag_i = FLAG_SAMPLE;
    end
  end

  // State and flag register; reset parks the sequencer in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      flag_o  <= FLAG_NONE;
    end else begin
      state_q <= nstate;
      flag_o  <= flag_i;
    end
  end

  // Next-state decode from (state, registered flag); watchdog overrides all.
  always_comb begin
    nstate = ST_IDLE;
    rst_ci = 1'b1;
    case (state_q)
      ST_IDLE: begin
        nstate = ST_SETTLE;
        rst_ci = 1'b1;
      end
      ST_SETTLE: begin
        if (flag_o == FLAG_SETTLE) begin
          nstate = ST_SAMP_V;
          rst_ci = 1'b1;
        end else begin
          nstate = ST_SETTLE;
          rst_ci = 1'b0;
        end
      end
      ST_SAMP_V: begin
        if (flag_o == FLAG_SAMPLE) begin
          nstate = ST_SAMP_I;
          rst_ci = 1'b1;
        end else begin
          nstate = ST_SAMP_V;
          rst_ci = 1'b0;
        end
      end
      ST_SAMP_I: begin
        if (flag_o == FLAG_SAMPLE) begin
          nstate = ST_CALC;
          rst_ci = 1'b1;
        end else begin
          nstate = ST_SAMP_I;
          rst_ci = 1'b0;
        end
      end
      ST_CALC: begin
        nstate = ST_UPDATE;
        rst_ci = 1'b1;
      end
      ST_UPDATE: begin
        nstate = ST_SETTLE;
        rst_ci = 1'b1;
      end
      default: begin
        nstate = ST_IDLE;
        rst_ci = 1'b1;
      end
    endcase
    if (flag_o == FLAG_WDOG) begin
      nstate = ST_IDLE;
      rst_ci = 1'b1;
    end
  end

  // Enables depend only on the registered state, so they are glitch-free
  // and at most one is ever active.
  always_comb begin
    en = EN_NONE;
    case (state_q)
      ST_SAMP_V: en = EN_SAMP_V;
      ST_SAMP_I: en = EN_SAMP_I;
      ST_CALC:   en = EN_CALC;
      ST_UPDATE: en = EN_UPDATE;
      default:   en = EN_NONE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mppt_sequencer.sv
// Self-checking bench for mppt_sequencer: directed timing points plus a
// phase/duration reference model checked every cycle under random resets.
module tb_mppt_sequencer;

  localparam int CNT_W  = 14;
  localparam int SETTLE = 9999;
  localparam int SAMPLE = 49;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [3:0]       en;
  logic [2:0]       state;
  logic [CNT_W-1:0] c_i;
  logic [1:0]       flag_o;

  int checks = 0;
  int errors = 0;
  int cyc    = -1;

  // Reference model: the current phase (by state code) and how many cycles
  // it has already lasted. Each phase has a fixed length and successor.
  int m_phase  = 0;
  int m_age    = 0;
  bit model_on = 1'b1;
  int ph_dur [6] = '{1, SETTLE + 2, SAMPLE + 2, SAMPLE + 2, 1, 1};
  int ph_next[6] = '{1, 2, 3, 4, 5, 1};
  int ph_en  [6] = '{0, 0, 1, 2, 4, 8};

  mppt_sequencer #(
    .CNT_W      (CNT_W),
    .SETTLE_CNT (SETTLE),
    .SAMPLE_CNT (SAMPLE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .state  (state),
    .c_i    (c_i),
    .flag_o (flag_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int flag_code(input int v);
    if (v == CMAX)   return 3;
    if (v == SETTLE) return 2;
    if (v == SAMPLE) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int exp_c;
    int exp_f;
    exp_c = (m_age > CMAX) ? CMAX : m_age;
    exp_f = (m_age >= 1) ? flag_code(exp_c - 1) : 0;
    chk("m_state",  32'(state),  32'(m_phase));
    chk("m_en",     32'(en),     32'(ph_en[m_phase]));
    chk("m_c_i",    32'(c_i),    32'(exp_c));
    chk("m_flag_o", 32'(flag_o), 32'(exp_f));
    chk("onehot",   32'($countones(en) <= 1), 32'd1);
    chk("legal_st", 32'(state < 3'd6), 32'd1);
  endtask

  // One clock edge: advance the model, then sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_phase = 0;
      m_age   = 0;
    end else begin
      m_age++;
      if (m_age == ph_dur[m_phase]) begin
        m_phase = ph_next[m_phase];
        m_age   = 0;
      end
    end
    #1;
    cyc++;
    if (model_on) check_model();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    int hold;
    rst = 1'b0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en",    32'(en),    32'd0);
    chk("rst_c_i",   32'(c_i),   32'd0);
    chk("rst_flag",  32'(flag_o), 32'd0);

    // Release; next edge is E0.
    rst = 1'b1;
    cyc = -1;
    tick();
    chk("e0_state", 32'(state), 32'd1);
    chk("e0_c_i",   32'(c_i),   32'd0);
    run_to(7);
    chk("e7_c_i", 32'(c_i), 32'd7);
    run_to(10000);
    chk("settle_flag", 32'(flag_o), 32'd2);
    run_to(10001);
    chk("sv_first_state", 32'(state), 32'd2);
    chk("sv_first_en",    32'(en),    32'd1);
    run_to(10051);
    chk("sv_last_en", 32'(en), 32'd1);
    run_to(10052);
    chk("si_first_en", 32'(en), 32'd2);
    run_to(10102);
    chk("si_last_en", 32'(en), 32'd2);
    run_to(10103);
    chk("calc_en", 32'(en), 32'd4);
    run_to(10104);
    chk("update_en", 32'(en), 32'd8);
    run_to(10105);
    chk("loop_state", 32'(state), 32'd1);
    chk("loop_c_i",   32'(c_i),   32'd0);
    run_to(20106);
    chk("loop2_sv_en", 32'(en), 32'd1);

    // One-cycle reset pulse while sampling current.
    run_to(20160);
    chk("pre_pulse_state", 32'(state), 32'd3);
    rst = 1'b0;
    tick();
    chk("pulse_state", 32'(state), 32'd0);
    chk("pulse_c_i",   32'(c_i),   32'd0);
    chk("pulse_en",    32'(en),    32'd0);
    rst = 1'b1;
    tick();
    chk("post_pulse_state", 32'(state), 32'd1);

    // Watchdog: overrun the counter while settling.
    for (int i = 0; i < 100; i++) tick();
    model_on = 1'b0;
    force dut.u_cnt.count = 14'h3fff;
    tick();
    chk("wd_flag", 32'(flag_o), 32'd3);
    chk("wd_c_i",  32'(c_i),    32'(CMAX));
    release dut.u_cnt.count;
    tick();
    chk("wd_idle_state", 32'(state), 32'd0);
    chk("wd_idle_en",    32'(en),    32'd0);
    tick();
    chk("wd_idle2_state", 32'(state), 32'd0);
    chk("wd_idle2_c_i",   32'(c_i),   32'd0);
    tick();
    chk("wd_resume_state", 32'(state), 32'd1);
    m_phase  = 1;
    m_age    = 0;
    model_on = 1'b1;
    check_model();

    // Random free run with rare reset pulses of random length.
    hold = 0;
    for (int i = 0; i < 40000; i++) begin
      if (hold > 0) begin
        rst = 1'b0;
        hold--;
      end else if ($urandom_range(0, 2999) == 0) begin
        rst  = 1'b0;
        hold = int'($urandom_range(0, 2));
      end else begin
        rst = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
